temporal_buffer_sequencer: RTL and testbench
============================================

Name: temporal_buffer_sequencer

Overview:
Controller that sequences one flip round through the temporal buffer array. It steps the buffer's write index across all NSAT candidate flips as the clause evaluator presents them, then waits for the heuristic selector's choice. It then drives the read index so the selected clause set can be handed downstream under a valid/ready handshake. It sits between the candidate evaluator, the heuristic selector and the temporal buffer array.

Parameters:
NSAT, 3, literals per clause; also the number of candidate flips per round
NSAT_BITS, 2, width of the write/read index; must satisfy 2^NSAT_BITS >= NSAT
SEL_TIMEOUT, 64, cycles to wait for a selection before fallback; used only with the optional feature

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
start_i  input  1  begin a flip round; sampled only in IDLE
cand_valid_i  input  1  evaluator presents candidate literal and clause-table data this cycle
cand_ready_o  output  1  sequencer accepts candidate; high only in WRITE
write_index_o  output  NSAT_BITS  buffer write index; slot being filled
wr_en_o  output  1  equals cand_valid_i & cand_ready_o; buffer captures this cycle
eval_done_o  output  1  one-cycle pulse after the last (NSAT-1) candidate is accepted
sel_valid_i  input  1  selector presents chosen flip index
sel_index_i  input  NSAT_BITS  chosen flip index
sel_ready_o  output  1  high only in SELECT
read_index_o  output  NSAT_BITS  buffer read index, held stable through OUTPUT
out_valid_o  output  1  selected clause set on buffer output is valid
out_ready_i  input  1  downstream accepts clause set
busy_o  output  1  high in any state other than IDLE
err_o  output  1  sticky; set when sel_index_i >= NSAT is offered; cleared by reset or start_i

Behaviour:
- States: IDLE, WRITE, SELECT, OUTPUT.
- Reset (reset==0 at a clk edge), from any state including mid-round:
  - state=IDLE.
  - write_index_o=0, read_index_o=0.
  - cand_ready_o, wr_en_o, eval_done_o, sel_ready_o, out_valid_o, busy_o, err_o all 0.
  - Partially written buffer contents are abandoned.
- IDLE:
  - start_i=1 -> WRITE next cycle; write_index_o=0; err_o cleared.
  - Other inputs are ignored.
- WRITE:
  - cand_ready_o=1.
  - Each cycle with cand_valid_i=1:
    - wr_en_o=1 combinationally with write_index_o = current slot.
    - On that edge, write_index_o increments.
  - On acceptance at slot NSAT-1:
    - write_index_o returns to 0 (no wrap into unused codes when NSAT < 2^NSAT_BITS).
    - eval_done_o pulses in the following cycle.
    - state -> SELECT.
  - cand_valid_i=0 stalls; the index holds.
- SELECT:
  - sel_ready_o=1.
  - sel_valid_i=1 with sel_index_i < NSAT:
    - read_index_o <= sel_index_i.
    - Next cycle: OUTPUT with out_valid_o=1.
    - Latency from selection to out_valid_o is exactly 1 cycle.
  - sel_index_i >= NSAT:
    - Handshake still completes.
    - err_o set; read_index_o <= 0; proceed to OUTPUT.
- OUTPUT:
  - out_valid_o=1 and read_index_o stable until out_ready_i=1.
  - On transfer: out_valid_o drops next cycle; state -> IDLE.
  - If start_i=1 on the transfer cycle: go directly to WRITE (back-to-back rounds, no idle bubble).
  - out_valid_o must not drop before transfer.
- start_i outside IDLE (and outside the OUTPUT transfer cycle) is ignored.
- Simultaneous handshakes are impossible by construction: only one ready is high per state.

Optional Feature:
TB_SEL_TIMEOUT_EN
- Defined:
  - A counter runs in SELECT, cleared on entry.
  - If sel_valid_i has not arrived after SEL_TIMEOUT cycles: read_index_o <= 0, err_o set, state -> OUTPUT.
  - A sel_valid_i on the timeout cycle takes priority over the timeout.
- Undefined:
  - No counter is built and SELECT waits indefinitely.
  - The SEL_TIMEOUT parameter is unused.

Test Plan:
- Basic round:
  - Stimulus: start_i; three back-to-back cand_valid_i; then sel_index_i=2.
  - Required: write_index_o 0,1,2 with wr_en_o high each cycle; eval_done_o pulses once; read_index_o=2 and out_valid_o high 1 cycle after the selection; busy_o low after out_ready_i.
- Stalls:
  - Stimulus: cand_valid_i gapped 1,0,0,1,0,1; out_ready_i held low 5 cycles.
  - Required: index advances only on valid cycles; out_valid_o and read_index_o stay stable for all 5 cycles.
- Illegal selection:
  - Stimulus: sel_index_i=3 with NSAT=3.
  - Required: err_o=1; read_index_o=0; round completes; next start_i clears err_o.
- Reset mid-round:
  - Stimulus: reset=0 after the 2nd candidate is accepted.
  - Required: all outputs 0 next cycle; a fresh start_i restarts at write_index_o=0.
- Back-to-back rounds:
  - Stimulus: start_i asserted on the OUTPUT transfer cycle.
  - Required: WRITE entered next cycle with cand_ready_o=1 and no IDLE cycle.
- Timeout (TB_SEL_TIMEOUT_EN, SEL_TIMEOUT=8):
  - Stimulus: no sel_valid_i.
  - Required: out_valid_o rises 9 cycles after entering SELECT, with read_index_o=0 and err_o=1.

Source files
------------

// File: rtl/temporal_buffer_sequencer.sv
// Sequences one flip round through the temporal buffer: fill NSAT slots, take the
// selector's choice, present it downstream. Optional selection timeout: TB_SEL_TIMEOUT_EN.
module temporal_buffer_sequencer #(
    parameter int unsigned NSAT        = 3,
    parameter int unsigned NSAT_BITS   = 2,
    parameter int unsigned SEL_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 cand_valid_i,
    output logic                 cand_ready_o,
    output logic [NSAT_BITS-1:0] write_index_o,
    output logic                 wr_en_o,
    output logic                 eval_done_o,
    input  logic                 sel_valid_i,
    input  logic [NSAT_BITS-1:0] sel_index_i,
    output logic                 sel_ready_o,
    output logic [NSAT_BITS-1:0] read_index_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 err_o
);

    // One extra bit so the legality compare still works when NSAT == 2**NSAT_BITS.
    localparam int unsigned IDX_EXT_W = NSAT_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_SELECT = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    // Illegal configurations elaborate an empty marker block and nothing else.
    if (((1 << NSAT_BITS) < NSAT) || (NSAT == 0) || (SEL_TIMEOUT == 0)) begin : g_bad_params
    end

    state_e               state_q;
    logic [NSAT_BITS-1:0] write_index_q;
    logic [NSAT_BITS-1:0] read_index_q;
    logic                 cand_ready_q;
    logic                 sel_ready_q;
    logic                 out_valid_q;
    logic                 eval_done_q;
    logic                 busy_q;
    logic                 err_q;

    logic                 accept_c;
    logic                 last_slot_c;
    logic                 sel_hs_c;
    logic                 sel_legal_c;
    logic                 out_hs_c;

`ifdef TB_SEL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(SEL_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    assign accept_c    = cand_valid_i & cand_ready_q;
    assign last_slot_c = (write_index_q == NSAT_BITS'(NSAT - 1));
    assign sel_hs_c    = sel_valid_i & sel_ready_q;
    assign sel_legal_c = (IDX_EXT_W'(sel_index_i) < IDX_EXT_W'(NSAT));
    assign out_hs_c    = out_valid_q & out_ready_i;

    // Round sequencer; every output except wr_en_o comes straight from a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            write_index_q <= '0;
            read_index_q  <= '0;
            cand_ready_q  <= 1'b0;
            sel_ready_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            eval_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef TB_SEL_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            eval_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q       <= S_WRITE;
                        cand_ready_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        write_index_q <= '0;
                        err_q         <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (accept_c) begin
                        if (last_slot_c) begin
                            state_q       <= S_SELECT;
                            write_index_q <= '0;
                            eval_done_q   <= 1'b1;
                            cand_ready_q  <= 1'b0;
                            sel_ready_q   <= 1'b1;
`ifdef TB_SEL_TIMEOUT_EN
                            to_cnt_q      <= '0;
`endif
                        end else begin
                            write_index_q <= write_index_q + NSAT_BITS'(1);
                        end
                    end
                end
                S_SELECT: begin
                    if (sel_hs_c) begin
                        state_q      <= S_OUTPUT;
                        sel_ready_q  <= 1'b0;
                        out_valid_q  <= 1'b1;
                        read_index_q <= sel_legal_c ? sel_index_i : '0;
                        if (!sel_legal_c) begin
                            err_q <= 1'b1;
                        end
`ifdef TB_SEL_TIMEOUT_EN
                    end else if (to_cnt_q == TO_W'(SEL_TIMEOUT)) begin
                        state_q      <= S_OUTPUT;
                        sel_ready_q  <= 1'b0;
                        out_valid_q  <= 1'b1;
                        read_index_q <= '0;
                        err_q        <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                    end
                end
                S_OUTPUT: begin
                    // A start on the transfer cycle chains straight into the next round.
                    if (out_hs_c) begin
                        out_valid_q <= 1'b0;
                        if (start_i) begin
                            state_q       <= S_WRITE;
                            cand_ready_q  <= 1'b1;
                            write_index_q <= '0;
                            err_q         <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cand_ready_o  = cand_ready_q;
    assign write_index_o = write_index_q;
    assign wr_en_o       = accept_c;
    assign eval_done_o   = eval_done_q;
    assign sel_ready_o   = sel_ready_q;
    assign read_index_o  = read_index_q;
    assign out_valid_o   = out_valid_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_temporal_buffer_sequencer.sv
// Directed bench for temporal_buffer_sequencer; the selected index/error of each round
// is queued at selection time and compared when the clause set transfers downstream.
module tb_temporal_buffer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic       cand_valid_i;
    logic       cand_ready_o;
    logic [1:0] write_index_o;
    logic       wr_en_o;
    logic       eval_done_o;
    logic       sel_valid_i;
    logic [1:0] sel_index_i;
    logic       sel_ready_o;
    logic [1:0] read_index_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       busy_o;
    logic       err_o;

    typedef struct {
        logic [1:0] idx;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    temporal_buffer_sequencer #(
        .NSAT        (3),
        .NSAT_BITS   (2),
        .SEL_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .cand_valid_i  (cand_valid_i),
        .cand_ready_o  (cand_ready_o),
        .write_index_o (write_index_o),
        .wr_en_o       (wr_en_o),
        .eval_done_o   (eval_done_o),
        .sel_valid_i   (sel_valid_i),
        .sel_index_i   (sel_index_i),
        .sel_ready_o   (sel_ready_o),
        .read_index_o  (read_index_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_cand_ready", 32'(cand_ready_o), 32'd1);
        chk("start_widx", 32'(write_index_o), 32'd0);
        chk("start_err_clear", 32'(err_o), 32'd0);
    endtask

    // Bit i of pat is cand_valid_i in cycle i; pattern must hold exactly three ones.
    task automatic feed(input logic [7:0] pat, input int len);
        int slot = 0;
        for (int i = 0; i < len; i++) begin
            cand_valid_i = pat[i];
            #1;
            chk("wr_en", 32'(wr_en_o), 32'(pat[i]));
            chk("widx", 32'(write_index_o), 32'(slot));
            tick();
            if (pat[i]) slot++;
        end
        cand_valid_i = 1'b0;
        #1;
        chk("eval_done_pulse", 32'(eval_done_o), 32'd1);
        chk("sel_ready", 32'(sel_ready_o), 32'd1);
        chk("cand_ready_off", 32'(cand_ready_o), 32'd0);
        chk("widx_return", 32'(write_index_o), 32'd0);
    endtask

    task automatic do_select(input logic [1:0] idx);
        exp_t e;
        e.idx = (idx < 2'd3) ? idx : 2'd0;
        e.err = (idx >= 2'd3);
        sb_q.push_back(e);
        sel_valid_i = 1'b1;
        sel_index_i = idx;
        tick();
        sel_valid_i = 1'b0;
        sel_index_i = 2'd0;
        chk("out_valid_latency", 32'(out_valid_o), 32'd1);
        chk("sel_ready_off", 32'(sel_ready_o), 32'd0);
        chk("eval_done_single", 32'(eval_done_o), 32'd0);
    endtask

    task automatic drain(input int stall, input logic nxt);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb_q.pop_front();
        out_ready_i = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_out_valid", 32'(out_valid_o), 32'd1);
            chk("stall_ridx", 32'(read_index_o), 32'(e.idx));
            tick();
        end
        out_ready_i = 1'b1;
        start_i     = nxt;
        #1;
        chk("xfer_out_valid", 32'(out_valid_o), 32'd1);
        chk("xfer_ridx", 32'(read_index_o), 32'(e.idx));
        chk("xfer_err", 32'(err_o), 32'(e.err));
        tick();
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        chk("post_out_valid", 32'(out_valid_o), 32'd0);
        chk("post_busy", 32'(busy_o), 32'(nxt));
        chk("post_cand_ready", 32'(cand_ready_o), 32'(nxt));
        chk("post_widx", 32'(write_index_o), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_cand_ready"}, 32'(cand_ready_o), 32'd0);
        chk({tag, "_sel_ready"}, 32'(sel_ready_o), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_eval_done"}, 32'(eval_done_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_widx"}, 32'(write_index_o), 32'd0);
        chk({tag, "_ridx"}, 32'(read_index_o), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        start_i      = 1'b0;
        cand_valid_i = 1'b0;
        sel_valid_i  = 1'b0;
        sel_index_i  = 2'd0;
        out_ready_i  = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Basic round
        start_round();
        feed(8'b0000_0111, 3);
        tick();
        chk("eval_done_drop", 32'(eval_done_o), 32'd0);
        chk("still_select", 32'(sel_ready_o), 32'd1);
        do_select(2'd2);
        drain(0, 1'b0);

        // Gapped candidates and downstream back-pressure
        start_round();
        feed(8'b0010_1001, 6);
        do_select(2'd1);
        drain(5, 1'b0);

        // Illegal selection: error sticks until the next start
        start_round();
        feed(8'b0000_0111, 3);
        do_select(2'd3);
        chk("illegal_err", 32'(err_o), 32'd1);
        chk("illegal_ridx", 32'(read_index_o), 32'd0);
        drain(0, 1'b0);
        chk("err_sticky_idle", 32'(err_o), 32'd1);

        // Reset after two accepted candidates
        start_round();
        cand_valid_i = 1'b1;
        tick();
        tick();
        chk("pre_reset_widx", 32'(write_index_o), 32'd2);
        cand_valid_i = 1'b0;
        reset        = 1'b0;
        tick();
        chk_all_zero("midreset");
        reset = 1'b1;
        tick();
        chk("post_reset_idle", 32'(busy_o), 32'd0);
        start_round();
        feed(8'b0000_0111, 3);
        do_select(2'd0);

        // Back-to-back: start on the transfer cycle goes straight to WRITE
        drain(2, 1'b1);
        feed(8'b0000_0111, 3);
        do_select(2'd2);
        drain(0, 1'b0);

`ifdef TB_SEL_TIMEOUT_EN
        begin
            exp_t e;
            int   cyc = 0;
            start_round();
            feed(8'b0000_0111, 3);
            e.idx = 2'd0;
            e.err = 1'b1;
            sb_q.push_back(e);
            while (!out_valid_o && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("timeout_latency", 32'(cyc), 32'd9);
            drain(0, 1'b0);
        end
`endif

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
